// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one command at a time, word-only memory, RMW for SB/SH.
// Ports: cmd_* / mem_rd_en / mem_wd_en / mem_type / addr / wdata in; done/err/rdata out; mem_* bus.
module lsu_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wd_en,
  input  logic [2:0]        mem_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, ERR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        type_q;
  logic              store_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic accept;
  logic is_ld, is_st, is_half, is_word;
  logic bad_op, bad_type, misal, illegal;
  logic unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept  = cmd_valid & cmd_ready;
  assign is_ld   = mem_rd_en & ~mem_wd_en;
  assign is_st   = mem_wd_en & ~mem_rd_en;
  assign is_half = (mem_type == 3'd1) | (mem_type == 3'd5);
  assign is_word = (mem_type == 3'd2);

  assign bad_op   = ~(is_ld | is_st);
  assign bad_type = (is_ld & ((mem_type == 3'd3) | (mem_type[2:1] == 2'b11)))
                  | (is_st & (mem_type > 3'd2));
  assign misal    = (is_half & addr[0]) | (is_word & (|addr[1:0]));
  assign illegal  = bad_op | bad_type | misal;

  // Load extraction and store merge, both from the word on mem_rdata
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = mem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign sx     = ~type_q[2];

  always_comb begin
    ld_val = mem_rdata;
    unique case (1'b1)
      type_q[1:0] == 2'd0: ld_val = {{24{byte_v[7] & sx}}, byte_v};
      type_q[1:0] == 2'd1: ld_val = {{16{half_v[15] & sx}}, half_v};
      default:             ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (type_q[1:0] == 2'd1)
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            illegal:               state_d = ERR;
            is_st & is_word:       state_d = WR_REQ;
            default:               state_d = RD_REQ;
          endcase
        end
      end
      RD_REQ:  if (mem_gnt) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_d = store_q ? WR_REQ : DONE;
      WR_REQ:  if (mem_gnt) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    mem_req   = (state_q == RD_REQ) | (state_q == WR_REQ);
    mem_we    = (state_q == WR_REQ);
    done      = (state_q == DONE) | (state_q == ERR);
    err       = (state_q == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      type_q  <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr[ADDR_W+1:0];
        type_q  <= mem_type;
        store_q <= is_st;
        wdata_q <= wdata;
      end
      if (state_q == RD_WAIT && mem_rvalid) begin
        if (store_q) wdata_q <= merged;
        else         rdata_q <= ld_val;
      end
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: directed commands, bus responder, done monitor.
// Expected results are pushed at issue time and popped when done pulses.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        mem_rd_en = 1'b0;
  logic        mem_wd_en = 1'b0;
  logic [2:0]  mem_type = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mem_rd_en(mem_rd_en), .mem_wd_en(mem_wd_en),
    .mem_type(mem_type), .addr(addr), .wdata(wdata),
    .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          gnts;
    int          wrs;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Cycle bookkeeping
  int cyc = 0, acc = 0, acc_gnt = 0, acc_wr = 0;
  int n_gnt = 0, n_wr = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc     <= cyc + 1;
      acc_gnt <= n_gnt;
      acc_wr  <= n_wr;
    end
  end

  // Bus responder configuration for the current command
  logic [31:0] rd_word = '0;
  int          gdly = 0, rvdly = 1;
  logic [31:0] cur_addr = '0, cur_wword = '0;

  initial begin : responder
    bit pend_rd = 0;
    int rv_cnt = 0, g_cnt = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend_rd) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_word;
          pend_rd    = 0;
        end
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        chk("req_addr", {24'h0, mem_addr}, cur_addr);
        if (mem_we) chk("wr_data", mem_wdata, cur_wword);
        if (g_cnt == gdly) begin
          mem_gnt = 1'b1;
          g_cnt   = 0;
          n_gnt++;
          if (mem_we) n_wr++;
          else begin
            pend_rd = 1;
            rv_cnt  = rvdly;
          end
        end else begin
          g_cnt++;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("err", {31'h0, err}, {31'h0, e.err});
          chk("rdata", rdata, e.rdata);
          chk("latency", cyc - acc + 1, e.lat);
          chk("grants", n_gnt - acc_gnt, e.gnts);
          chk("writes", n_wr - acc_wr, e.wrs);
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wd, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] wd_v,
                       input logic [31:0] word, input int gd, input int rvd,
                       input bit e_err, input logic [31:0] e_rdata,
                       input int e_lat, input int e_gnts, input int e_wrs,
                       input logic [31:0] e_wword, input bit push);
    exp_t e;
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    rd_word   = word;
    gdly      = gd;
    rvdly     = rvd;
    cur_addr  = {26'h0, a[9:2]};
    cur_wword = e_wword;
    e.err = e_err; e.rdata = e_rdata; e.lat = e_lat;
    e.gnts = e_gnts; e.wrs = e_wrs;
    if (push) sbq.push_back(e);
    mem_rd_en = rd;
    mem_wd_en = wd;
    mem_type  = t;
    addr      = a;
    wdata     = wd_v;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'h0, cmd_ready}, 32'd1);
    chk({tag, "_done"}, {31'h0, done}, 32'd0);
    chk({tag, "_err"}, {31'h0, err}, 32'd0);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'd0);
    chk({tag, "_we"}, {31'h0, mem_we}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_maddr"}, {24'h0, mem_addr}, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  initial begin : main
    int k;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    // rd wd type addr wdata word gd rvd | err rdata lat gnts wrs wword push
    issue(1,0,3'd2,32'h10,0,32'hDEADBEEF,0,2, 0,32'hDEADBEEF,4,1,0,0,1);
    issue(1,0,3'd0,32'h13,0,32'h80FF7F01,0,1, 0,32'hFFFFFF80,3,1,0,0,1);
    issue(1,0,3'd4,32'h13,0,32'h80FF7F01,0,1, 0,32'h00000080,3,1,0,0,1);
    issue(1,0,3'd0,32'h11,0,32'h80FF7F01,0,1, 0,32'h0000007F,3,1,0,0,1);
    issue(1,0,3'd1,32'h10,0,32'h80FF7F01,0,1, 0,32'h00007F01,3,1,0,0,1);
    issue(1,0,3'd1,32'h12,0,32'h80FF7F01,0,1, 0,32'hFFFF80FF,3,1,0,0,1);
    issue(1,0,3'd5,32'h12,0,32'h80FF7F01,0,1, 0,32'h000080FF,3,1,0,0,1);
    issue(0,1,3'd0,32'h21,32'h000000AA,32'h11223344,0,1,
          0,32'h000080FF,4,2,1,32'h1122AA44,1);
    issue(0,1,3'd1,32'h22,32'h1234BEEF,32'h11223344,0,1,
          0,32'h000080FF,4,2,1,32'hBEEF3344,1);
    issue(0,1,3'd1,32'h01,32'hFFFF,0,0,1, 1,32'h000080FF,1,0,0,0,1);
    issue(1,0,3'd2,32'h02,0,0,0,1, 1,32'h000080FF,1,0,0,0,1);
    issue(1,1,3'd2,32'h00,0,0,0,1, 1,32'h000080FF,1,0,0,0,1);
    issue(1,0,3'd3,32'h00,0,0,0,1, 1,32'h000080FF,1,0,0,0,1);
    issue(0,1,3'd4,32'h00,0,0,0,1, 1,32'h000080FF,1,0,0,0,1);
    issue(0,1,3'd2,32'h08,32'h5A5A5A5A,0,3,1,
          0,32'h000080FF,5,1,1,32'h5A5A5A5A,1);

    // Reset while waiting for read data; rvalid then arrives late
    issue(1,0,3'd2,32'h04,0,32'hCAFEF00D,0,3, 0,0,0,0,0,0,0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("postrst");
    issue(1,0,3'd2,32'h04,0,32'h01234567,0,1, 0,32'h01234567,3,1,0,0,1);

    k = 0;
    while (sbq.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
